// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : whack_pkg
// Purpose : Shared constants and types for the whack-a-mole button front end.
// Contents: N_BTN             - number of player buttons (mole holes)
//           DB_CYCLES_DEFAULT - default debounce length in synchronised cycles
//           IDX_W             - width of a button index
//           btn_idx_t         - button index type
// Revision: 1.0 - initial release
// ============================================================================
package whack_pkg;

  localparam int N_BTN             = 4;
  localparam int DB_CYCLES_DEFAULT = 16;
  // Guarded so a single-button build still gets a 1-bit index.
  localparam int IDX_W             = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  typedef logic [IDX_W-1:0] btn_idx_t;

endpackage : whack_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : One button: two-flop synchroniser, stability counter and
//           debounced level register.
// Ports   : clk        in  system clock
//           rst_n      in  asynchronous active-low reset
//           raw        in  raw asynchronous button level (1 = pressed)
//           level      out debounced level (registered)
//           level_next out value level takes at the next clk edge; lets the
//                          parent detect a rise in the same cycle the level
//                          register updates
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce
  import whack_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic level_next
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Counter tracks how long the synchronised input has disagreed with the
  // accepted level; any agreement restarts the count, so glitches shorter
  // than DB_CYCLES samples are absorbed.
  always_comb begin
    level_next = level;
    cnt_next   = '0;
    if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level_next = ~level;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/whack_button_rx.sv
`default_nettype none
// ============================================================================
// Module  : whack_button_rx
// Purpose : Button front end for the whack-a-mole game. Debounces each raw
//           button, detects rising edges and hands press events to the game
//           FSM through a one-deep valid/ready holding register.
// Ports   : clk         in  system clock
//           rst_n       in  asynchronous active-low reset
//           btn_raw     in  raw button levels, asynchronous, 1 = pressed
//           btn_level   out debounced button levels
//           press_valid out holding register contains a press event
//           press_idx   out lowest index among buttons that rose together
//           press_multi out more than one button rose in the captured cycle
//           press_ready in  consumer accepts event on valid && ready
//           overrun     out sticky: a press event was dropped
//           clr_overrun in  synchronous clear of overrun
// Revision: 1.0 - initial release
// ============================================================================
module whack_button_rx
  import whack_pkg::*;
#(
  parameter int  N_BTN     = whack_pkg::N_BTN,
  parameter int  DB_CYCLES = DB_CYCLES_DEFAULT,
  localparam int IDX_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             press_valid,
  output logic [IDX_W-1:0] press_idx,
  output logic             press_multi,
  input  logic             press_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  logic [N_BTN-1:0] level_next;
  logic [N_BTN-1:0] rise;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_multi;
  logic             ev_any;
  logic             ev_load;
  logic             ev_drop;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .level_next (level_next[i])
    );
  end

  // Rise is taken from the level about to be registered, so the event lands
  // in the holding register on the same edge that btn_level goes high.
  assign rise = level_next & ~btn_level;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    ev_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) begin
        ev_idx = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more rose.
  assign ev_multi = |(rise & (rise - N_BTN'(1)));
  assign ev_any   = |rise;
  assign ev_load  = ev_any && (!press_valid || press_ready);
  assign ev_drop  = ev_any && press_valid && !press_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_valid <= 1'b0;
      press_idx   <= '0;
      press_multi <= 1'b0;
    end else if (ev_load) begin
      press_valid <= 1'b1;
      press_idx   <= ev_idx;
      press_multi <= ev_multi;
    end else if (!ev_any && press_valid && press_ready) begin
      press_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear request keeps the flag set, so a
  // lost event is never silently forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ev_drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule : whack_button_rx
`default_nettype wire

// File: tb/tb_whack_button_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_whack_button_rx
// Purpose : Self-checking bench for whack_button_rx (DB_CYCLES = 4).
//           Inputs change 1 time unit after each rising clk edge; outputs are
//           compared on the falling edge against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_whack_button_rx;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int IW = 2;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic [N-1:0]  btn_raw     = '0;
  logic          press_ready = 1'b0;
  logic          clr_overrun = 1'b0;
  logic [N-1:0]  btn_level;
  logic          press_valid;
  logic [IW-1:0] press_idx;
  logic          press_multi;
  logic          overrun;

  always #5 clk = ~clk;

  whack_button_rx #(
    .N_BTN     (N),
    .DB_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .press_valid (press_valid),
    .press_idx   (press_idx),
    .press_multi (press_multi),
    .press_ready (press_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          multi;
  } ev_t;

  ev_t          exp_q[$];
  logic [N-1:0] m_level   = '0;
  logic [N-1:0] m_raw_d0  = '0;   // raw as seen one edge ago
  logic [N-1:0] m_raw_d1  = '0;   // raw as seen two edges ago
  bit           hist[N][DB];      // most recent DB synchronised samples
  logic         m_valid   = 1'b0;
  logic         m_overrun = 1'b0;

  task automatic model_step();
    logic [N-1:0] s, nl, rise;
    ev_t          ev;
    bit           all_diff, drop;
    if (!rst_n) begin
      m_level = '0; m_raw_d0 = '0; m_raw_d1 = '0;
      m_valid = 1'b0; m_overrun = 1'b0;
      for (int i = 0; i < N; i++)
        for (int k = 0; k < DB; k++) hist[i][k] = 1'b0;
      exp_q.delete();
      return;
    end
    s        = m_raw_d1;
    m_raw_d1 = m_raw_d0;
    m_raw_d0 = btn_raw;
    nl = m_level;
    // A level flips once DB consecutive samples all disagree with it.
    for (int i = 0; i < N; i++) begin
      for (int k = DB - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = s[i];
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (hist[i][k] == m_level[i]) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_level[i];
    end
    rise = nl & ~m_level;
    drop = 1'b0;
    if (rise != 0) begin
      ev.idx = '0;
      for (int i = N - 1; i >= 0; i--) if (rise[i]) ev.idx = IW'(i);
      ev.multi = ($countones(rise) > 1);
      if (!m_valid || press_ready) begin
        exp_q.push_back(ev);
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && press_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_overrun = 1'b1;
    else if (clr_overrun) m_overrun = 1'b0;
    m_level = nl;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // -------------------------------------------------------------- monitor
  initial forever begin
    @(negedge clk);
    check("btn_level", int'(btn_level), int'(m_level));
    check("press_valid", int'(press_valid), int'(m_valid));
    check("overrun", int'(overrun), int'(m_overrun));
    if (press_valid) begin
      check("event_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("press_idx", int'(press_idx), int'(exp_q[0].idx));
        check("press_multi", int'(press_multi), int'(exp_q[0].multi));
        if (press_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!press_valid && k < 20) begin
      tick(1);
      k++;
    end
    check(name, int'(press_valid), 1);
  endtask

  initial begin
    int hi;

    // Reset with every button held, then release and let them debounce.
    rst_n = 1'b0; btn_raw = 4'b1111; press_ready = 1'b0;
    tick(3);
    check("rst_valid", int'(press_valid), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_idx", int'(press_idx), 0);
    rst_n = 1'b1;
    tick(5);
    check("rst_lvl_e5", int'(btn_level), 0);
    tick(1);
    check("rst_lvl_e6", int'(btn_level), 15);
    check("rst_valid_e6", int'(press_valid), 1);
    check("rst_idx_e6", int'(press_idx), 0);
    check("rst_multi_e6", int'(press_multi), 1);
    press_ready = 1'b1;
    tick(1);
    check("rst_accept", int'(press_valid), 0);
    btn_raw = '0;
    tick(10);

    // Single press on button 2, then release.
    btn_raw = 4'b0100;
    tick(5);
    check("single_e5", int'(press_valid), 0);
    tick(1);
    check("single_valid", int'(press_valid), 1);
    check("single_idx", int'(press_idx), 2);
    tick(1);
    check("single_drop", int'(press_valid), 0);
    btn_raw = '0;
    tick(10);
    check("release_no_event", int'(press_valid), 0);

    // Glitch rejection: 3 cycles absorbed, 4 cycles accepted.
    btn_raw = 4'b0010;
    tick(3);
    btn_raw = '0;
    tick(10);
    check("glitch3_level", int'(btn_level), 0);
    btn_raw = 4'b0010;
    tick(4);
    btn_raw = '0;
    hi = 0;
    for (int c = 0; c < 14; c++) begin
      tick(1);
      if (btn_level[1]) hi++;
    end
    check("pulse4_width", hi, 4);

    // Simultaneous rise of buttons 1 and 3.
    btn_raw = 4'b1010;
    tick(6);
    check("simul_valid", int'(press_valid), 1);
    check("simul_idx", int'(press_idx), 1);
    check("simul_multi", int'(press_multi), 1);
    btn_raw = '0;
    tick(10);

    // Overrun: held event survives a dropped one.
    press_ready = 1'b0;
    btn_raw = 4'b0001;
    wait_valid("ovr_wait");
    btn_raw = 4'b1001;
    tick(8);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_idx", int'(press_idx), 0);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("ovr_clear", int'(overrun), 0);
    press_ready = 1'b1;
    tick(1);
    check("ovr_accept", int'(press_valid), 0);
    btn_raw = '0;
    tick(10);

    // Accept and new load on the same edge.
    press_ready = 1'b0;
    btn_raw = 4'b0001;
    wait_valid("swap_wait");
    btn_raw = 4'b1001;
    tick(5);
    press_ready = 1'b1;
    tick(1);
    check("swap_valid", int'(press_valid), 1);
    check("swap_idx", int'(press_idx), 3);
    check("swap_overrun", int'(overrun), 0);
    tick(1);
    check("swap_accept", int'(press_valid), 0);
    btn_raw = '0;
    tick(10);

    // Random phase, including a reset in the middle of activity.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
      press_ready = ($urandom_range(0, 2) != 0);
      clr_overrun = ($urandom_range(0, 19) == 0);
      rst_n = (c < 200 || c > 202);
      tick(1);
    end

    btn_raw = '0; press_ready = 1'b1; clr_overrun = 1'b0; rst_n = 1'b1;
    tick(20);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_whack_button_rx
`default_nettype wire
